// File: rtl/l2_output_encoder.sv
// l2_output_encoder: five independent valid/ready output FIFOs with stall, idle and sticky overflow flags
//  l2_out_fifo       : one circular FIFO channel (push side, valid/ready pop side, count, drop strobe)
//  l2_output_encoder : clk, rst; per channel {ch} in req_out|rsp_out|fwd_out|rd_rsp|inval:
//                      l2_{ch}_push/_data_in (in), l2_{ch}_valid_int/_data (out), l2_{ch}_ready_int (in);
//                      out_stall, out_idle, ovf_err (out)
module l2_out_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [W-1:0]           i_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [W-1:0]           o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_pop, w_push_ok;
  // a full channel still accepts a push when the head leaves in the same cycle
  assign w_pop     = o_valid & i_ready;
  assign w_push_ok = i_push & ((r_count < CW'(DEPTH)) | w_pop);
  assign o_drop    = i_push & ~w_push_ok;
  assign o_valid   = r_count != '0;
  assign o_data    = r_mem[r_rd_ptr];
  assign o_count   = r_count;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push_ok) - CW'(w_pop);
    end
  end
endmodule

module l2_output_encoder #(
  parameter int DEPTH = 4,
  parameter int REQ_W = 128,
  parameter int RSP_W = 160,
  parameter int FWD_W = 160,
  parameter int RD_W  = 128,
  parameter int INV_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             l2_req_out_push,
  input  logic [REQ_W-1:0] l2_req_out_data_in,
  output logic             l2_req_out_valid_int,
  input  logic             l2_req_out_ready_int,
  output logic [REQ_W-1:0] l2_req_out_data,
  input  logic             l2_rsp_out_push,
  input  logic [RSP_W-1:0] l2_rsp_out_data_in,
  output logic             l2_rsp_out_valid_int,
  input  logic             l2_rsp_out_ready_int,
  output logic [RSP_W-1:0] l2_rsp_out_data,
  input  logic             l2_fwd_out_push,
  input  logic [FWD_W-1:0] l2_fwd_out_data_in,
  output logic             l2_fwd_out_valid_int,
  input  logic             l2_fwd_out_ready_int,
  output logic [FWD_W-1:0] l2_fwd_out_data,
  input  logic             l2_rd_rsp_push,
  input  logic [RD_W-1:0]  l2_rd_rsp_data_in,
  output logic             l2_rd_rsp_valid_int,
  input  logic             l2_rd_rsp_ready_int,
  output logic [RD_W-1:0]  l2_rd_rsp_data,
  input  logic             l2_inval_push,
  input  logic [INV_W-1:0] l2_inval_data_in,
  output logic             l2_inval_valid_int,
  input  logic             l2_inval_ready_int,
  output logic [INV_W-1:0] l2_inval_data,
  output logic             out_stall,
  output logic             out_idle,
  output logic             ovf_err
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [CW-1:0] w_count [5];
  logic [4:0]    w_drop;
  logic          r_ovf_err;
  l2_out_fifo #(.DEPTH(DEPTH), .W(REQ_W)) u_req (
    .clk(clk), .rst(rst), .i_push(l2_req_out_push), .i_data(l2_req_out_data_in),
    .o_valid(l2_req_out_valid_int), .i_ready(l2_req_out_ready_int), .o_data(l2_req_out_data),
    .o_count(w_count[0]), .o_drop(w_drop[0]));
  l2_out_fifo #(.DEPTH(DEPTH), .W(RSP_W)) u_rsp (
    .clk(clk), .rst(rst), .i_push(l2_rsp_out_push), .i_data(l2_rsp_out_data_in),
    .o_valid(l2_rsp_out_valid_int), .i_ready(l2_rsp_out_ready_int), .o_data(l2_rsp_out_data),
    .o_count(w_count[1]), .o_drop(w_drop[1]));
  l2_out_fifo #(.DEPTH(DEPTH), .W(FWD_W)) u_fwd (
    .clk(clk), .rst(rst), .i_push(l2_fwd_out_push), .i_data(l2_fwd_out_data_in),
    .o_valid(l2_fwd_out_valid_int), .i_ready(l2_fwd_out_ready_int), .o_data(l2_fwd_out_data),
    .o_count(w_count[2]), .o_drop(w_drop[2]));
  l2_out_fifo #(.DEPTH(DEPTH), .W(RD_W)) u_rd (
    .clk(clk), .rst(rst), .i_push(l2_rd_rsp_push), .i_data(l2_rd_rsp_data_in),
    .o_valid(l2_rd_rsp_valid_int), .i_ready(l2_rd_rsp_ready_int), .o_data(l2_rd_rsp_data),
    .o_count(w_count[3]), .o_drop(w_drop[3]));
  l2_out_fifo #(.DEPTH(DEPTH), .W(INV_W)) u_inv (
    .clk(clk), .rst(rst), .i_push(l2_inval_push), .i_data(l2_inval_data_in),
    .o_valid(l2_inval_valid_int), .i_ready(l2_inval_ready_int), .o_data(l2_inval_data),
    .o_count(w_count[4]), .o_drop(w_drop[4]));
  // stall at DEPTH-1 leaves one slot for the issue already in flight behind decode
  always_comb begin
    out_stall = 1'b0;
    out_idle  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      out_stall = out_stall | (w_count[i] >= CW'(DEPTH - 1));
      out_idle  = out_idle & (w_count[i] == '0);
    end
  end
  always_ff @(posedge clk) begin
    r_ovf_err <= rst ? 1'b0 : (r_ovf_err | (|w_drop));
  end
  assign ovf_err = r_ovf_err;
endmodule

// File: tb/tb_l2_output_encoder.sv
// tb_l2_output_encoder: directed checks of the five-channel L2 output encoder
module tb_l2_output_encoder;
  logic clk = 1'b0, rst;
  logic req_push, req_v, req_rdy; logic [127:0] req_din, req_d;
  logic rsp_push, rsp_v, rsp_rdy; logic [159:0] rsp_din, rsp_d;
  logic fwd_push, fwd_v, fwd_rdy; logic [159:0] fwd_din, fwd_d;
  logic rd_push,  rd_v,  rd_rdy;  logic [127:0] rd_din,  rd_d;
  logic inv_push, inv_v, inv_rdy; logic [31:0]  inv_din, inv_d;
  logic stall, idle, ovf;
  int n_chk = 0, n_fail = 0;
  logic [127:0] q [$];

  always #5 clk = ~clk;

  l2_output_encoder dut (
    .clk(clk), .rst(rst),
    .l2_req_out_push(req_push), .l2_req_out_data_in(req_din), .l2_req_out_valid_int(req_v),
    .l2_req_out_ready_int(req_rdy), .l2_req_out_data(req_d),
    .l2_rsp_out_push(rsp_push), .l2_rsp_out_data_in(rsp_din), .l2_rsp_out_valid_int(rsp_v),
    .l2_rsp_out_ready_int(rsp_rdy), .l2_rsp_out_data(rsp_d),
    .l2_fwd_out_push(fwd_push), .l2_fwd_out_data_in(fwd_din), .l2_fwd_out_valid_int(fwd_v),
    .l2_fwd_out_ready_int(fwd_rdy), .l2_fwd_out_data(fwd_d),
    .l2_rd_rsp_push(rd_push), .l2_rd_rsp_data_in(rd_din), .l2_rd_rsp_valid_int(rd_v),
    .l2_rd_rsp_ready_int(rd_rdy), .l2_rd_rsp_data(rd_d),
    .l2_inval_push(inv_push), .l2_inval_data_in(inv_din), .l2_inval_valid_int(inv_v),
    .l2_inval_ready_int(inv_rdy), .l2_inval_data(inv_d),
    .out_stall(stall), .out_idle(idle), .ovf_err(ovf));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    {req_push, rsp_push, fwd_push, rd_push, inv_push} = 5'h1f;
    {req_rdy, rsp_rdy, fwd_rdy, rd_rdy, inv_rdy} = 5'h1f;
    req_din = 128'h55; rsp_din = 160'h66; fwd_din = 160'h77; rd_din = 128'h88; inv_din = 32'h99;
    // 1 reset with pushes asserted
    tick();
    tick();
    rst = 1'b0;
    {req_push, rsp_push, fwd_push, rd_push, inv_push} = 5'h0;
    {req_rdy, rsp_rdy, fwd_rdy, rd_rdy, inv_rdy} = 5'h0;
    chk("rst_valid", {155'd0, req_v, rsp_v, fwd_v, rd_v, inv_v}, 160'd0);
    chk("rst_idle", idle, 1);
    chk("rst_ovf", ovf, 0);
    chk("rst_stall", stall, 0);
    chk("rst_req_data", req_d, 0);
    chk("rst_rsp_data", rsp_d, 0);
    // 2 single req_out
    req_rdy = 1'b1; req_push = 1'b1; req_din = 128'hA5;
    tick();
    req_push = 1'b0;
    chk("req_valid_t1", req_v, 1);
    chk("req_data_t1", req_d, 128'hA5);
    chk("req_idle_t1", idle, 0);
    tick();
    chk("req_valid_t2", req_v, 0);
    chk("req_idle_t2", idle, 1);
    // 3 backpressure and overflow on rsp_out
    rsp_push = 1'b1;
    rsp_din = 160'd1; tick();
    rsp_din = 160'd2; tick();
    chk("bp_stall_2", stall, 0);
    rsp_din = 160'd3; tick();
    chk("bp_stall_3", stall, 1);
    rsp_din = 160'd4; tick();
    chk("bp_ovf_4", ovf, 0);
    rsp_din = 160'd5; tick();
    rsp_push = 1'b0;
    chk("bp_ovf_5", ovf, 1);
    chk("bp_hold", rsp_d, 160'd1);
    rsp_rdy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("bp_order_valid", rsp_v, 1);
      chk("bp_order_data", rsp_d, 160'(i));
      tick();
    end
    chk("bp_empty", rsp_v, 0);
    chk("bp_ovf_sticky", ovf, 1);
    rsp_rdy = 1'b0;
    do_reset();
    chk("ovf_cleared", ovf, 0);
    // 4 push+pop on a full fwd_out
    fwd_push = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      fwd_din = 160'(i * 'h11);
      tick();
    end
    chk("fp_head", fwd_d, 160'h11);
    fwd_rdy = 1'b1; fwd_din = 160'd9;
    tick();
    fwd_push = 1'b0;
    chk("fp_stall", stall, 1);
    chk("fp_ovf", ovf, 0);
    chk("fp_d0", fwd_d, 160'h22); tick();
    chk("fp_d1", fwd_d, 160'h33); tick();
    chk("fp_d2", fwd_d, 160'h44); tick();
    chk("fp_d3", fwd_d, 160'd9);
    chk("fp_v3", fwd_v, 1); tick();
    chk("fp_empty", fwd_v, 0);
    chk("fp_idle", idle, 1);
    fwd_rdy = 1'b0;
    // 5 independence: inval full and blocked, rd_rsp flows
    inv_push = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inv_din = 32'(i + 'h40);
      tick();
    end
    inv_push = 1'b0;
    chk("ind_stall0", stall, 1);
    rd_rdy = 1'b1; rd_push = 1'b1; rd_din = 128'd7;
    tick();
    rd_din = 128'd8;
    chk("ind_rd7", rd_d, 128'd7);
    chk("ind_v7", rd_v, 1);
    chk("ind_stall1", stall, 1);
    tick();
    rd_push = 1'b0;
    chk("ind_rd8", rd_d, 128'd8);
    chk("ind_v8", rd_v, 1);
    chk("ind_stall2", stall, 1);
    tick();
    chk("ind_rd_empty", rd_v, 0);
    chk("ind_stall3", stall, 1);
    chk("ind_inv_head", inv_d, 32'h40);
    chk("ind_ovf", ovf, 0);
    rd_rdy = 1'b0;
    do_reset();
    chk("ind_reset_idle", idle, 1);
    chk("ind_reset_inv", inv_v, 0);
    // 6 wrap on req_out with random ready against a queue model
    begin
      int sent = 0;
      int cyc = 0;
      bit pop;
      while ((sent < 10 || q.size() != 0) && cyc < 200) begin
        req_rdy = 1'($urandom_range(0, 1));
        req_push = (sent < 10) && (q.size() < 4);
        req_din = 128'(sent + 'h100);
        chk("wr_valid", req_v, q.size() != 0);
        if (q.size() != 0) chk("wr_data", req_d, q[0]);
        pop = (q.size() != 0) && req_rdy;
        tick();
        if (pop) void'(q.pop_front());
        if (req_push) begin
          q.push_back(req_din);
          sent++;
        end
        cyc++;
      end
      req_push = 1'b0;
      chk("wr_done_in_budget", cyc < 200, 1);
      chk("wr_idle", idle, 1);
      chk("wr_valid_end", req_v, 0);
      chk("wr_ovf", ovf, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
